// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and bit-mixing functions for the schedule and compression stages.
// Pure declarations; no state.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int N_ROUNDS    = 64;
  localparam int N_BLK_WORDS = 16;
  localparam int ROUND_W     = $clog2(N_ROUNDS);
  localparam int LOAD_CNT_W  = $clog2(N_BLK_WORDS);

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  function automatic word_t rotr32(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  // Round-function helpers used by the compression stage.
  function automatic word_t big_sigma0(input word_t x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

  function automatic word_t ch32(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj32(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_sched_expand.sv
// Combinational schedule expansion: next window word from taps 0, 1, 9 and 14 (mod 2^32).
// Kept as its own module so the four-operand adder tree can be timed in isolation.
module sha256_sched_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] win0,
  input  logic [WORD_W-1:0] win1,
  input  logic [WORD_W-1:0] win9,
  input  logic [WORD_W-1:0] win14,
  output logic [WORD_W-1:0] w_new
);

  logic [WORD_W-1:0] s0, s1;

  assign s0    = small_sigma0(win1);
  assign s1    = small_sigma1(win14);
  assign w_new = s1 + win9 + s0 + win0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W0..W63 one per w_valid/w_ready handshake.
// First w_valid the cycle after the 16th load; stalls hold w_out/w_round and freeze the window.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_word,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [WORD_W-1:0]   w_out,
  output logic [ROUND_W-1:0]  w_round,
  output logic                busy,
  output logic                done
);

  localparam logic [LOAD_CNT_W-1:0] LAST_LOAD  = LOAD_CNT_W'(N_BLK_WORDS - 1);
  localparam logic [ROUND_W-1:0]    LAST_ROUND = ROUND_W'(N_ROUNDS - 1);

  sched_state_t                         state_q, state_d;
  logic [N_BLK_WORDS-1:0][WORD_W-1:0]   win_q, win_d;
  logic [LOAD_CNT_W-1:0]                load_cnt_q, load_cnt_d;
  logic [ROUND_W-1:0]                   round_q, round_d;
  logic [WORD_W-1:0]                    w_new;
  logic                                 load_hs, run_hs;

  sha256_sched_expand u_expand (
    .win0  (win_q[0]),
    .win1  (win_q[1]),
    .win9  (win_q[9]),
    .win14 (win_q[14]),
    .w_new (w_new)
  );

  assign load_hs = (state_q == LOAD) && in_valid;
  assign run_hs  = (state_q == RUN) && w_ready;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    load_cnt_d = load_cnt_q;
    round_d    = round_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (load_hs) begin
          win_d      = {in_word, win_q[N_BLK_WORDS-1:1]};
          load_cnt_d = load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_LOAD) begin
            state_d = RUN;
            round_d = '0;
          end
        end
      end
      RUN: begin
        if (run_hs) begin
          win_d = {w_new, win_q[N_BLK_WORDS-1:1]};
          // Explicit clear on the last round rather than relying on the 6-bit wrap.
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
            round_d = '0;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      win_q      <= '0;
      load_cnt_q <= '0;
      round_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      load_cnt_q <= load_cnt_d;
      round_q    <= round_d;
    end
  end

  // Every output is a direct decode of flopped state, so nothing combinational leaks out.
  assign in_ready = (state_q == LOAD);
  assign w_valid  = (state_q == RUN);
  assign w_out    = win_q[0];
  assign w_round  = round_q;
  assign busy     = (state_q == LOAD) || (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule with a software schedule model feeding a scoreboard queue.
module tb_sha256_msg_schedule;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_out;
  logic [5:0]  w_round;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [37:0] sbq   [$];

  sha256_msg_schedule dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .w_round  (w_round),
    .busy     (busy),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Build the reference schedule for blk[] and queue (round, word) pairs.
  task automatic push_block(input bit abc_ref);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
    if (abc_ref) begin
      exp_w[16] = 32'h61626380;
      exp_w[17] = 32'h000F0000;
      exp_w[18] = 32'h7DA86405;
    end
    for (int t = 0; t < 64; t++) sbq.push_back({6'(t), exp_w[t]});
  endtask

  task automatic set_abc();
    blk[0] = 32'h61626380;
    for (int i = 1; i < 15; i++) blk[i] = 32'h0;
    blk[15] = 32'h00000018;
  endtask

  // Starts in IDLE; leaves the 16th word on the bus for the next posedge to accept.
  task automatic load_block(input bit gap, input int start_word);
    @(posedge CLK); #1;
    start = 1'b1; in_valid = 1'b0;
    @(negedge CLK);
    check("idle_done_low", 32'(done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (gap && i == 8) begin
        for (int g = 0; g < 3; g++) begin
          @(posedge CLK); #1;
          start = 1'b0; in_valid = 1'b0;
          @(negedge CLK);
          check("gap_in_ready", 32'(in_ready), 32'd1);
          check("gap_no_valid", 32'(w_valid), 32'd0);
        end
      end
      @(posedge CLK); #1;
      start    = (i == start_word);
      in_valid = 1'b1;
      in_word  = blk[i];
      @(negedge CLK);
      check("load_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic drain(input bit bp, input int start_round, input int rst_round);
    int          n_hs = 0;
    int          cyc = 0;
    bit          first = 1'b1;
    bit          prev_stall = 1'b0;
    bit          fin = 1'b0;
    bit          saw_done = 1'b0;
    logic [31:0] p_out = '0;
    logic [5:0]  p_rnd = '0;
    logic [37:0] e;
    while (!fin && cyc < 1000) begin
      cyc++;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (n_hs == start_round);
      if (n_hs == rst_round) begin
        RST = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1; w_ready = 1'b0; start = 1'b0;
        @(negedge CLK);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 100; k++) begin
          @(negedge CLK);
          if (done) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        sbq.delete();
        return;
      end
      @(negedge CLK);
      if (first) begin
        check("first_w_valid", 32'(w_valid), 32'd1);
        first = 1'b0;
      end
      if (prev_stall) begin
        check("stall_w_out", w_out, p_out);
        check("stall_w_round", 32'(w_round), 32'(p_rnd));
      end
      if (w_valid && w_ready) begin
        check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("w_out", w_out, e[31:0]);
          check("w_round", 32'(w_round), 32'(e[37:32]));
        end
        n_hs++;
      end
      prev_stall = w_valid && !w_ready;
      p_out      = w_out;
      p_rnd      = w_round;
      if (n_hs == 64) begin
        @(posedge CLK); #1;
        w_ready = 1'b0; start = 1'b0;
        @(negedge CLK);
        check("done_pulse", 32'(done), 32'd1);
        check("done_no_valid", 32'(w_valid), 32'd0);
        fin = 1'b1;
      end
    end
    check("handshakes", 32'(n_hs), 32'd64);
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; in_valid = 1'b0; in_word = '0; w_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_w_valid", 32'(w_valid), 32'd0);
    check("reset_w_out", w_out, 32'd0);
    check("reset_w_round", 32'(w_round), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    RST = 1'b1;

    set_abc();
    push_block(1'b1);
    load_block(1'b0, -1);
    drain(1'b0, -1, -1);

    push_block(1'b1);
    load_block(1'b0, -1);
    drain(1'b1, -1, -1);

    push_block(1'b1);
    load_block(1'b1, -1);
    drain(1'b0, -1, -1);

    push_block(1'b1);
    load_block(1'b0, 5);
    drain(1'b0, 20, -1);

    push_block(1'b1);
    load_block(1'b0, -1);
    drain(1'b0, -1, 30);

    push_block(1'b1);
    load_block(1'b0, -1);
    drain(1'b0, -1, -1);

    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    push_block(1'b0);
    load_block(1'b0, -1);
    drain(1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
